// File: rtl/window_median3x3.sv
`default_nettype none
// ============================================================================
// Module   : window_median3x3
// Brief    : Three-stage pipelined 3x3 median filter on IEEE half-precision
//            windows with frame-position tagging. Optional macro
//            MEDIAN_BORDER_PASS_EN passes the centre element through for
//            border windows instead of suppressing them.
// Revision : 1.0 - initial release
// ============================================================================
module window_median3x3 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iValid,
    input  logic [DATA_WIDTH*9-1:0] iData,
    output logic                    oValid,
    output logic [DATA_WIDTH-1:0]   oData,
    output logic                    oLast
);

    localparam int c_cw = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_rw = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [c_cw-1:0] c_col_last = c_cw'(IMG_WIDTH - 1);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(IMG_HEIGHT - 1);

    // Sign-magnitude to unsigned ordering key; -0 is folded onto +0 so they compare equal.
    function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] x);
        if (x[DATA_WIDTH-1]) begin
            if (x[DATA_WIDTH-2:0] == '0) f_key = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else                         f_key = ~x;
        end else begin
            f_key = x | {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_min(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        f_min = (f_key(b) < f_key(a)) ? b : a;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        f_max = (f_key(b) > f_key(a)) ? b : a;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_med3(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b,
                                                     input logic [DATA_WIDTH-1:0] c);
        f_med3 = f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    // ------------------------------------------------------------------
    // Window position counters and tags
    // ------------------------------------------------------------------
    logic [c_cw-1:0] col_q;
    logic [c_rw-1:0] row_q;
    logic            w_interior;
    logic            w_last;

    assign w_interior = (32'(col_q) >= 32'd2) && (32'(row_q) >= 32'd2);
    assign w_last     = (col_q == c_col_last) && (row_q == c_row_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (iValid) begin
            if (col_q == c_col_last) begin
                col_q <= '0;
                row_q <= (row_q == c_row_last) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-row sort
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_elem [9];
    logic [DATA_WIDTH-1:0] w_rmin [3];
    logic [DATA_WIDTH-1:0] w_rmid [3];
    logic [DATA_WIDTH-1:0] w_rmax [3];

    generate
        for (genvar k = 0; k < 9; k++) begin : g_elem
            assign w_elem[k] = iData[DATA_WIDTH*(9-k)-1 -: DATA_WIDTH];
        end
        for (genvar r = 0; r < 3; r++) begin : g_row
            assign w_rmin[r] = f_min(f_min(w_elem[3*r], w_elem[3*r+1]), w_elem[3*r+2]);
            assign w_rmax[r] = f_max(f_max(w_elem[3*r], w_elem[3*r+1]), w_elem[3*r+2]);
            assign w_rmid[r] = f_med3(w_elem[3*r], w_elem[3*r+1], w_elem[3*r+2]);
        end
    endgenerate

    logic [DATA_WIDTH-1:0] s1_min_q [3];
    logic [DATA_WIDTH-1:0] s1_mid_q [3];
    logic [DATA_WIDTH-1:0] s1_max_q [3];
    logic                  s1_valid_q;
    logic                  s1_int_q;
    logic                  s1_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                s1_min_q[r] <= '0;
                s1_mid_q[r] <= '0;
                s1_max_q[r] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_int_q   <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                s1_min_q[r] <= w_rmin[r];
                s1_mid_q[r] <= w_rmid[r];
                s1_max_q[r] <= w_rmax[r];
            end
            s1_valid_q <= iValid;
            s1_int_q   <= w_interior;
            s1_last_q  <= w_last;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: max-of-mins, median-of-mids, min-of-maxes
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] s2_lo_q;
    logic [DATA_WIDTH-1:0] s2_md_q;
    logic [DATA_WIDTH-1:0] s2_hi_q;
    logic                  s2_valid_q;
    logic                  s2_int_q;
    logic                  s2_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_lo_q    <= '0;
            s2_md_q    <= '0;
            s2_hi_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_int_q   <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s2_lo_q    <= f_max(f_max(s1_min_q[0], s1_min_q[1]), s1_min_q[2]);
            s2_md_q    <= f_med3(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
            s2_hi_q    <= f_min(f_min(s1_max_q[0], s1_max_q[1]), s1_max_q[2]);
            s2_valid_q <= s1_valid_q;
            s2_int_q   <= s1_int_q;
            s2_last_q  <= s1_last_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final median / border handling
    // ------------------------------------------------------------------
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_med;
    logic [DATA_WIDTH-1:0] w_out_d;

    assign w_med = f_med3(s2_lo_q, s2_md_q, s2_hi_q);

`ifdef MEDIAN_BORDER_PASS_EN
    // Centre element rides alongside the sort network for border pass-through.
    logic [DATA_WIDTH-1:0] s1_ctr_q;
    logic [DATA_WIDTH-1:0] s2_ctr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctr_q <= '0;
            s2_ctr_q <= '0;
        end else begin
            s1_ctr_q <= w_elem[4];
            s2_ctr_q <= s1_ctr_q;
        end
    end

    assign w_emit  = s2_valid_q;
    assign w_out_d = s2_int_q ? w_med : s2_ctr_q;
`else
    assign w_emit  = s2_valid_q & s2_int_q;
    assign w_out_d = w_med;
`endif

    logic                  out_valid_q;
    logic                  out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= w_emit;
            out_last_q  <= w_emit & s2_last_q;
            if (w_emit) out_data_q <= w_out_d;
        end
    end

    assign oValid = out_valid_q;
    assign oLast  = out_last_q;
    assign oData  = out_data_q;

endmodule
`default_nettype wire

// File: doc/window_median3x3.md
WINDOW_MEDIAN3X3 -- requirements
Module: window_median3x3

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width (IEEE half-precision, sign at MSB).
REQ-002 Parameter IMG_WIDTH, default 8, windows per image row.
REQ-003 Parameter IMG_HEIGHT, default 8, rows per frame.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 iValid  input  1  iData carries a new 3x3 window this cycle.
REQ-007 iData  input  DATA_WIDTH*9  window, row-major, element (1,1) in the MSBs, element (3,3) in the LSBs.
REQ-008 oValid  output  1  oData holds a result this cycle.
REQ-009 oData  output  DATA_WIDTH  median (or pass-through centre) result.
REQ-010 oLast  output  1  asserted with oValid on the final result of a frame.

Function
REQ-011 Ordering SHALL be float ordering: key = sign ? ~x : x | MSB; compare keys unsigned; -0 and +0 equal; NaN ordered by key, no special case.
REQ-012 Stage 1 SHALL sort each window row into (min, mid, max), registered.
REQ-013 Stage 2 SHALL register max-of-mins, median-of-mids, min-of-maxes.
REQ-014 Stage 3 SHALL register median of the three stage-2 values into oData.
REQ-015 Latency SHALL be exactly 3 clocks from the iValid sampling edge to oValid; no stall, one window per clock throughput.
REQ-016 Equal keys SHALL yield either equal operand; result value is identical.
REQ-017 Column counter SHALL increment per accepted window, wrap IMG_WIDTH-1 -> 0 and increment row counter; row counter wraps IMG_HEIGHT-1 -> 0.
REQ-018 A window is interior when column >= 2 and row >= 2; otherwise border.
REQ-019 oLast SHALL assert with the result of the window at column IMG_WIDTH-1, row IMG_HEIGHT-1.
REQ-020 Gaps in iValid SHALL hold counters; in-flight pipeline results still emerge on schedule.
REQ-021 Window-position tags (interior, last) SHALL travel in the pipeline alongside data.

Reset
REQ-022 On rst_n low: oValid=0, oLast=0, oData=0, all stage registers and counters 0, immediately.
REQ-023 Reset mid-frame SHALL discard in-flight windows; first window after release is column 0, row 0.

Configuration
REQ-024 Macro MEDIAN_BORDER_PASS_EN defined: border windows SHALL emit oValid with oData = unfiltered centre element (2,2), same 3-clock latency.
REQ-025 MEDIAN_BORDER_PASS_EN undefined: border windows SHALL NOT assert oValid; counters still advance; oLast asserts only if last window is interior (always true for IMG_WIDTH, IMG_HEIGHT >= 3).

Verification
REQ-026 Interior window {9,1,5,3,7,2,8,4,6}.0 -> oValid after 3 clocks, oData=0x4500 (5.0).
REQ-027 Interior window {-3,-2,-1,0,1,2,3,4,5} shuffled -> oData=0x3C00 (1.0); all -1.0 (0xBC00) -> 0xBC00.
REQ-028 Window with +0 (0x0000) and -0 (0x8000) as middle values -> result key equals zero, either encoding accepted.
REQ-029 Full 8x8 frame, continuous iValid -> 36 outputs without macro, 64 with macro; oLast on final output only.
REQ-030 Random iValid gaps over two frames -> output sequence matches gap-free golden model; counters wrap correctly between frames.
REQ-031 rst_n pulsed low with 2 windows in flight -> no stale oValid after release; next frame numbering restarts at (0,0).
